// File: rtl/attn_sched_pkg.sv
// Shared types and constants for the attention-pipeline scheduler blocks.
// Holds the arbiter state encoding, the requester index map and the default sizing.
package attn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_Q   = 0;
  localparam int REQ_K   = 1;
  localparam int REQ_V   = 2;
  localparam int REQ_QKT = 3;
  localparam int REQ_RES = 4;

  localparam int NREQ_DEF    = 5;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/mm_engine_arbiter_if.sv
// Requester/engine-side handshake bundle of the shared matrix-multiply arbiter.
// The master modport is the arbiter; slave is the requester and engine side.
interface mm_engine_arbiter_if
  import attn_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            mm_start;
  logic            mm_done;
  logic [NREQ-1:0] req_done;
  logic            busy;
  logic            timeout_err;

  modport master (
    input  req, mm_done,
    output grant, sel, mm_start, req_done, busy, timeout_err
  );

  modport slave (
    output req, mm_done,
    input  grant, sel, mm_start, req_done, busy, timeout_err
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set req bit searching last+1, last+2, ... modulo NREQ.
// Purely combinational, zero latency; no backpressure (valid simply follows |req).
module rr_priority_pick
  import attn_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic            valid,
  output logic [SELW-1:0] index
);

  // Walk offsets from farthest to nearest so the nearest hit after last wins.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NREQ]) begin
        index = SELW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mm_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one matrix-multiply engine among NREQ stages.
// Latency: grant 1 cycle after req; req_done 1 cycle after accepted done; 2 cycles turnaround.
// Backpressure: requesters hold req until req_done; a hung engine is aborted after TIMEOUT cycles.
module mm_engine_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               reset,
  mm_engine_arbiter_if.master bus
);

  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Wide enough to reach TIMEOUT-1 and still saturate cleanly when the timeout is off.
  localparam int CNTW = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_t      state;
  logic [SELW-1:0] last;
  logic [CNTW-1:0] cnt;
  logic [NREQ-1:0] grant_r;
  logic [SELW-1:0] sel_r;
  logic            mm_start_r;
  logic [NREQ-1:0] req_done_r;
  logic            busy_r;
  logic            timeout_err_r;

  logic            pick_vld;
  logic [SELW-1:0] pick_idx;
  logic            done_ok;
  logic            to_hit;

  rr_priority_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req),
    .last  (last),
    .valid (pick_vld),
    .index (pick_idx)
  );

  // A done seen on the first RUN cycle may be left over from the previous job.
  assign done_ok = bus.mm_done && (cnt != '0);
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last          <= SELW'(NREQ - 1);
      cnt           <= '0;
      grant_r       <= '0;
      sel_r         <= '0;
      mm_start_r    <= 1'b0;
      req_done_r    <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state      <= RUN;
            sel_r      <= pick_idx;
            grant_r    <= NREQ'(1) << pick_idx;
            mm_start_r <= 1'b1;
            busy_r     <= 1'b1;
            cnt        <= '0;
          end
        end
        RUN: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          if (done_ok || to_hit) begin
            state      <= RELEASE;
            grant_r    <= '0;
            mm_start_r <= 1'b0;
            req_done_r <= NREQ'(1) << sel_r;
            last       <= sel_r;
            if (!done_ok) begin
              timeout_err_r <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state      <= IDLE;
          req_done_r <= '0;
          busy_r     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          grant_r    <= '0;
          mm_start_r <= 1'b0;
          req_done_r <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_r;
  assign bus.sel         = sel_r;
  assign bus.mm_start    = mm_start_r;
  assign bus.req_done    = req_done_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mm_engine_arbiter.sv
// Directed bench for mm_engine_arbiter with hand-computed expectations per scenario.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mm_engine_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mm_engine_arbiter_if #(.NREQ(5)) ifc ();

  mm_engine_arbiter #(
    .NREQ    (5),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    ifc.req = '0;
    ifc.mm_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  // From the first RUN cycle: one more RUN cycle, then done, landing in RELEASE.
  task automatic finish_job;
    tick();
    ifc.mm_done = 1'b1;
    tick();
    ifc.mm_done = 1'b0;
  endtask

  task automatic test_reset;
    ifc.req = '0;
    ifc.mm_done = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    n_checks++; if (ifc.grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant got %b want 00000", ifc.grant); end
    n_checks++; if (ifc.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", ifc.sel); end
    n_checks++; if (ifc.mm_start !== 1'b0) begin n_fail++; $display("FAIL reset_mm_start got %b want 0", ifc.mm_start); end
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL reset_req_done got %b want 00000", ifc.req_done); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
    n_checks++; if (ifc.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", ifc.timeout_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_request;
    ifc.req = 5'b00001;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++; if (ifc.grant !== 5'b00001) begin n_fail++; $display("FAIL single_grant c%0d got %b want 00001", c, ifc.grant); end
      n_checks++; if (ifc.sel !== 3'd0) begin n_fail++; $display("FAIL single_sel c%0d got %0d want 0", c, ifc.sel); end
      n_checks++; if (ifc.mm_start !== 1'b1) begin n_fail++; $display("FAIL single_mm_start c%0d got %b want 1", c, ifc.mm_start); end
      n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL single_req_done_early c%0d got %b want 00000", c, ifc.req_done); end
      if (c == 5) ifc.mm_done = 1'b1;
    end
    tick();
    n_checks++; if (ifc.req_done !== 5'b00001) begin n_fail++; $display("FAIL single_req_done c6 got %b want 00001", ifc.req_done); end
    n_checks++; if (ifc.grant !== 5'b0) begin n_fail++; $display("FAIL single_release_grant got %b want 00000", ifc.grant); end
    n_checks++; if (ifc.mm_start !== 1'b0) begin n_fail++; $display("FAIL single_release_start got %b want 0", ifc.mm_start); end
    n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL single_release_busy got %b want 1", ifc.busy); end
    ifc.req = '0;
    tick();
    ifc.mm_done = 1'b0;
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy c7 got %b want 0", ifc.busy); end
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL single_idle_req_done c7 got %b want 00000", ifc.req_done); end
  endtask

  task automatic test_contention;
    logic [4:0] exp;
    apply_reset();
    ifc.req = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      exp = 5'b00001 << k;
      tick();
      n_checks++; if (ifc.grant !== exp) begin n_fail++; $display("FAIL contend_grant k%0d got %b want %b", k, ifc.grant, exp); end
      n_checks++; if (ifc.sel !== 3'(k)) begin n_fail++; $display("FAIL contend_sel k%0d got %0d want %0d", k, ifc.sel, k); end
      tick();
      n_checks++; if (!$onehot0(ifc.grant)) begin n_fail++; $display("FAIL contend_onehot k%0d got %b want zero or one-hot", k, ifc.grant); end
      tick();
      ifc.mm_done = 1'b1;
      tick();
      n_checks++; if (ifc.req_done !== exp) begin n_fail++; $display("FAIL contend_req_done k%0d got %b want %b", k, ifc.req_done, exp); end
      ifc.req = ifc.req & ~exp;
      ifc.mm_done = 1'b0;
      tick();
      n_checks++; if (ifc.grant !== 5'b0) begin n_fail++; $display("FAIL contend_idle_grant k%0d got %b want 00000", k, ifc.grant); end
    end
  endtask

  task automatic test_round_robin_wrap;
    apply_reset();
    ifc.req = 5'b00100;
    tick();
    n_checks++; if (ifc.grant !== 5'b00100) begin n_fail++; $display("FAIL rr_first got %b want 00100", ifc.grant); end
    finish_job();
    ifc.req = 5'b00101;
    tick();
    tick();
    n_checks++; if (ifc.grant !== 5'b00001) begin n_fail++; $display("FAIL rr_wrap got %b want 00001", ifc.grant); end
    finish_job();
    ifc.req = 5'b00100;
    tick();
    tick();
    n_checks++; if (ifc.grant !== 5'b00100) begin n_fail++; $display("FAIL rr_after_wrap got %b want 00100", ifc.grant); end
    n_checks++; if (ifc.sel !== 3'd2) begin n_fail++; $display("FAIL rr_after_wrap_sel got %0d want 2", ifc.sel); end
    finish_job();
    ifc.req = '0;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    apply_reset();
    ifc.req = 5'b00010;
    tick();
    n = 0;
    while (ifc.mm_start === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL timeout_run_len got %0d want 16", n); end
    n_checks++; if (ifc.req_done !== 5'b00010) begin n_fail++; $display("FAIL timeout_req_done got %b want 00010", ifc.req_done); end
    n_checks++; if (ifc.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %b want 1", ifc.timeout_err); end
    ifc.req = '0;
    tick();
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL timeout_pulse_width got %b want 00000", ifc.req_done); end
    n_checks++; if (ifc.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", ifc.timeout_err); end
    ifc.req = 5'b00001;
    tick();
    n_checks++; if (ifc.grant !== 5'b00001) begin n_fail++; $display("FAIL timeout_next_grant got %b want 00001", ifc.grant); end
    finish_job();
    n_checks++; if (ifc.req_done !== 5'b00001) begin n_fail++; $display("FAIL timeout_next_done got %b want 00001", ifc.req_done); end
    n_checks++; if (ifc.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_still_sticky got %b want 1", ifc.timeout_err); end
    ifc.req = '0;
    tick();
  endtask

  task automatic test_stale_done;
    ifc.req = 5'b01000;
    ifc.mm_done = 1'b1;
    tick();
    n_checks++; if (ifc.grant !== 5'b01000) begin n_fail++; $display("FAIL stale_grant got %b want 01000", ifc.grant); end
    tick();
    n_checks++; if (ifc.mm_start !== 1'b1) begin n_fail++; $display("FAIL stale_second_run got %b want 1", ifc.mm_start); end
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL stale_not_accepted got %b want 00000", ifc.req_done); end
    tick();
    n_checks++; if (ifc.req_done !== 5'b01000) begin n_fail++; $display("FAIL stale_req_done got %b want 01000", ifc.req_done); end
    ifc.req = '0;
    ifc.mm_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run;
    apply_reset();
    ifc.req = 5'b01000;
    tick();
    tick();
    tick();
    n_checks++; if (ifc.mm_start !== 1'b1) begin n_fail++; $display("FAIL midrst_running got %b want 1", ifc.mm_start); end
    reset = 1'b1;
    #1;
    n_checks++; if (ifc.mm_start !== 1'b0) begin n_fail++; $display("FAIL midrst_mm_start got %b want 0", ifc.mm_start); end
    n_checks++; if (ifc.grant !== 5'b0) begin n_fail++; $display("FAIL midrst_grant got %b want 00000", ifc.grant); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", ifc.busy); end
    n_checks++; if (ifc.sel !== 3'd0) begin n_fail++; $display("FAIL midrst_sel got %0d want 0", ifc.sel); end
    ifc.req = 5'b11000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL midrst_no_done got %b want 00000", ifc.req_done); end
    tick();
    n_checks++; if (ifc.grant !== 5'b01000) begin n_fail++; $display("FAIL midrst_regrant got %b want 01000", ifc.grant); end
    n_checks++; if (ifc.sel !== 3'd3) begin n_fail++; $display("FAIL midrst_regrant_sel got %0d want 3", ifc.sel); end
    n_checks++; if (ifc.req_done !== 5'b0) begin n_fail++; $display("FAIL midrst_no_done_run got %b want 00000", ifc.req_done); end
    finish_job();
    n_checks++; if (ifc.req_done !== 5'b01000) begin n_fail++; $display("FAIL midrst_new_done got %b want 01000", ifc.req_done); end
    ifc.req = 5'b10000;
    tick();
    tick();
    n_checks++; if (ifc.grant !== 5'b10000) begin n_fail++; $display("FAIL midrst_next_grant got %b want 10000", ifc.grant); end
    finish_job();
    ifc.req = '0;
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    ifc.req     = '0;
    ifc.mm_done = 1'b0;
    test_reset();
    test_single_request();
    test_contention();
    test_round_robin_wrap();
    test_timeout();
    test_stale_done();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: run still active, want completion");
    $fatal(1, "watchdog");
  end

endmodule
